alu_pipe: RTL

//  Registered, parametrised ALU for the RISC CPU datapath; next generation of the

---
 rtl/alu_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered parametrised ALU with valid/ready issue and shift-add multiply
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] accum,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     psum;
  logic [WIDTH:0]     alu_res;
  logic               zero_pend;
  logic               issue;
  logic               is_mul;
  logic               last_step;

  // Only one op in flight: the multiplier owns the block until its result is written.
  assign in_ready  = (state == S_IDLE);
  assign busy      = ~in_ready;
  assign issue     = in_valid & in_ready;
  assign is_mul    = MUL_EN && (opcode == 4'hC);
  assign last_step = (state == S_MUL) && (cnt == CW'(1));

  // Single-cycle result; bit WIDTH carries the carry/borrow/shifted-out flag.
  always_comb begin
    alu_res = {1'b0, accum};
    case (opcode)
      4'h2:    alu_res = {1'b0, accum} + {1'b0, data};
      4'h3:    alu_res = {1'b0, accum & data};
      4'h4:    alu_res = {1'b0, accum ^ data};
      4'h5:    alu_res = {1'b0, data};
      4'h8:    alu_res = {1'b0, accum} - {1'b0, data};
      4'h9:    alu_res = {1'b0, accum | data};
      4'hA:    alu_res = {accum, 1'b0};
      4'hB:    alu_res = {accum[0], 1'b0, accum[WIDTH-1:1]};
      default: alu_res = {1'b0, accum};
    endcase
  end

  // One shift-add step: add multiplicand into the high half when the current
  // multiplier bit (prod[0]) is set, then shift the whole product right.
  always_comb begin
    psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {psum, prod[WIDTH-1:1]};
  end

  // Next-state logic: a MUL runs exactly WIDTH steps, then returns to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue && is_mul) state_nxt = S_MUL;
      S_MUL:   if (cnt == CW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts a multiply in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: capture operands at issue, step the multiplier, publish results.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      prod      <= '0;
      zero_pend <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (issue) begin
        if (is_mul) begin
          mcand     <= accum;
          prod      <= {{WIDTH{1'b0}}, data};
          cnt       <= CW'(WIDTH);
          zero_pend <= (accum == '0);
        end else begin
          out       <= alu_res[WIDTH-1:0];
          carry     <= alu_res[WIDTH];
          zero      <= (accum == '0);
          out_valid <= 1'b1;
        end
      end else if (state == S_MUL) begin
        prod <= prod_nxt;
        cnt  <= cnt - CW'(1);
        if (last_step) begin
          out       <= prod_nxt[WIDTH-1:0];
          carry     <= |prod_nxt[2*WIDTH-1:WIDTH];
          zero      <= zero_pend;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
